// File: rtl/tx_pkg.sv
// Shared definitions for the TX interpolation stage.
//   IQ_W     : default width of each I / Q component
//   state_e  : interpolator FSM states
//   pack_iq / iq_i / iq_q : helpers to build and split an {I,Q} word
package tx_pkg;

  localparam int IQ_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } state_e;

  function automatic logic [2*IQ_W-1:0] pack_iq(input logic signed [IQ_W-1:0] i,
                                                input logic signed [IQ_W-1:0] q);
    return {i, q};
  endfunction

  function automatic logic signed [IQ_W-1:0] iq_i(input logic [2*IQ_W-1:0] d);
    return $signed(d[2*IQ_W-1:IQ_W]);
  endfunction

  function automatic logic signed [IQ_W-1:0] iq_q(input logic [2*IQ_W-1:0] d);
    return $signed(d[IQ_W-1:0]);
  endfunction

endpackage

// File: rtl/tx_lin_interp_lane.sv
// One component (I or Q) of the linear interpolator, purely combinational.
//   prev, cur : segment start / end values (signed DATA_W)
//   k         : sample index within the segment
//   s         : prev + floor((cur - prev) * k / 2^LOG2_L)
// The result always lies between prev and cur, so it is truncated back to
// DATA_W bits without saturation.
module lin_interp_lane #(
  parameter int DATA_W = 12,
  parameter int LOG2_L = 3
) (
  input  logic signed [DATA_W-1:0] prev,
  input  logic signed [DATA_W-1:0] cur,
  input  logic        [LOG2_L-1:0] k,
  output logic signed [DATA_W-1:0] s
);

  // Common working width: DATA_W+1 for the difference, plus LOG2_L for k.
  localparam int PW = DATA_W + LOG2_L + 1;

  logic signed [PW-1:0] prev_x, cur_x, k_x, prod, sum;

  always_comb begin
    prev_x = PW'(prev);
    cur_x  = PW'(cur);
    k_x    = $signed(PW'(k));          // k is unsigned: zero-extend
    prod   = (cur_x - prev_x) * k_x;   // exact, |prod| < 2^(DATA_W+LOG2_L)
    sum    = prev_x + (prod >>> LOG2_L); // arithmetic shift: floor
    s      = sum[DATA_W-1:0];
  end

endmodule

// File: rtl/tx_lin_interp.sv
// TX linear-interpolation upsampler (L = 2^LOG2_L) with ramp-down tail.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : AXIS input handshake, in_data = {I, Q}
//   out_valid/out_ready  : AXIS output handshake, out_data = {I, Q}
//   underrun             : one-cycle pulse when the ramp-to-zero tail starts
// Each accepted symbol ends the segment that is currently being emitted, so
// symbol X appears as k=0 of the segment after it; bursts start and end at 0.
module tx_lin_interp
  import tx_pkg::*;
#(
  parameter int DATA_W = IQ_W,
  parameter int LOG2_L = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [2*DATA_W-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [2*DATA_W-1:0] out_data,
  input  logic                out_ready,
  output logic                underrun
);

  localparam int               W2     = 2 * DATA_W;
  localparam logic [LOG2_L-1:0] K_LAST = '1;

  state_e            state_q, state_d;
  logic [W2-1:0]     prev_q, prev_d, cur_q, cur_d;
  logic [W2-1:0]     out_data_q, out_data_d, samp;
  logic [LOG2_L-1:0] k_q, k_d;
  logic              out_valid_q, out_valid_d, underrun_q, underrun_d;
  logic              xfer, k_last, load;

  always_comb begin
    xfer       = out_valid_q && out_ready;
    k_last     = (k_q == K_LAST);
    in_ready   = (state_q == IDLE) || (state_q == RUN && k_last && out_ready);
    state_d    = state_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    k_d        = k_q;
    underrun_d = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        // prev is 0 here (reset or end of tail), so the burst ramps up from 0
        if (in_valid) begin
          cur_d   = in_data;
          k_d     = '0;
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (xfer) begin
          load = 1'b1;
          if (!k_last) begin
            k_d = k_q + 1'b1;
          end else begin
            prev_d = cur_q;
            k_d    = '0;
            if (in_valid) begin
              cur_d = in_data;
            end else begin
              cur_d      = '0;
              state_d    = TAIL;
              underrun_d = 1'b1;
            end
          end
        end
      end
      TAIL: begin
        if (xfer) begin
          load = 1'b1;
          if (!k_last) begin
            k_d = k_q + 1'b1;
          end else begin
            prev_d  = '0;
            k_d     = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d != IDLE);
  end

  // Sample for the next (prev, cur, k); one lane per component.
  for (genvar g = 0; g < 2; g++) begin : g_lane
    lin_interp_lane #(.DATA_W(DATA_W), .LOG2_L(LOG2_L)) u_lane (
      .prev (prev_d[g*DATA_W +: DATA_W]),
      .cur  (cur_d [g*DATA_W +: DATA_W]),
      .k    (k_d),
      .s    (samp  [g*DATA_W +: DATA_W])
    );
  end

  // Hold under backpressure; reload on transfer or segment start.
  assign out_data_d = load ? samp : out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      cur_q       <= '0;
      k_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      k_q         <= k_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_tx_lin_interp.sv
// Self-checking bench for tx_lin_interp: directed bursts from the test plan
// plus random symbols and random output backpressure, compared against a
// segment-by-segment interpolation model.
module tb_tx_lin_interp;
  import tx_pkg::*;

  typedef logic [2*IQ_W-1:0] w_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready, underrun;
  w_t   in_data, out_data;

  int checks = 0;
  int failures = 0;

  w_t in_q[$];
  w_t exp_q[$];
  w_t got_q[$];
  int acc_cyc[$];
  int und_cnt, und_cyc, first_out, last_out;

  always #5 clk = ~clk;

  tx_lin_interp #(.DATA_W(IQ_W), .LOG2_L(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .underrun  (underrun)
  );

  // ---------------- reference model ----------------
  // A burst visits the points 0, X0, X1, ..., Xn-1, 0 and each pair of
  // neighbouring points yields 8 samples a + floor((b-a)*k/8).
  function automatic w_t mk(input int i, input int q);
    logic [IQ_W-1:0] ri, rq;
    ri = i[IQ_W-1:0];
    rq = q[IQ_W-1:0];
    return {ri, rq};
  endfunction

  task automatic add_segment(input int ai, input int aq, input int bi, input int bq);
    for (int k = 0; k < 8; k++)
      exp_q.push_back(mk(ai + (((bi - ai) * k) >>> 3), aq + (((bq - aq) * k) >>> 3)));
  endtask

  task automatic build_exp();
    int pi, pq;
    exp_q.delete();
    pi = 0;
    pq = 0;
    foreach (in_q[n]) begin
      add_segment(pi, pq, int'(iq_i(in_q[n])), int'(iq_q(in_q[n])));
      pi = int'(iq_i(in_q[n]));
      pq = int'(iq_q(in_q[n]));
    end
    add_segment(pi, pq, 0, 0);
  endtask

  // ---------------- stimulus engine ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Feed in_q back-to-back and collect transfers until exp_q.size() outputs
  // are seen; inputs are applied at negedge and observed 1 time unit later.
  task automatic run(input int stall_pct, input string name);
    int idx, cyc;
    bit stalled;
    w_t last;
    idx = 0; cyc = 0; stalled = 0; last = '0;
    got_q.delete(); acc_cyc.delete();
    und_cnt = 0; und_cyc = -1; first_out = -1; last_out = -1;
    while (got_q.size() < exp_q.size() && cyc < 5000) begin
      @(negedge clk);
      in_valid  = (idx < in_q.size());
      in_data   = (idx < in_q.size()) ? in_q[idx] : '0;
      out_ready = ($urandom_range(99) >= stall_pct);
      #1;
      if (stalled) begin
        checks++;
        if (out_data !== last) begin
          failures++;
          $display("FAIL %s stall_hold: got %h required %h", name, out_data, last);
        end
      end
      stalled = out_valid && !out_ready;
      last = out_data;
      if (in_valid && in_ready) begin idx++; acc_cyc.push_back(cyc); end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (underrun) begin und_cnt++; und_cyc = cyc; end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s timeout: got %0d outputs required %0d", name, got_q.size(), exp_q.size());
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after: out_valid %b required 0", name, out_valid);
    end
    checks++;
    if (und_cnt != 1) begin
      failures++;
      $display("FAIL %s underrun_count: got %0d required 1", name, und_cnt);
    end
    foreach (got_q[n]) begin
      checks++;
      if (got_q[n] !== exp_q[n]) begin
        failures++;
        $display("FAIL %s sample[%0d]: got %h required %h", name, n, got_q[n], exp_q[n]);
      end
    end
  endtask

  task automatic check_iq(input string name, input int n, input int ei, input int eq);
    checks++;
    if (n >= got_q.size() || int'(iq_i(got_q[n])) != ei || int'(iq_q(got_q[n])) != eq) begin
      failures++;
      if (n < got_q.size())
        $display("FAIL %s[%0d]: got I=%0d Q=%0d required I=%0d Q=%0d", name, n,
                 int'(iq_i(got_q[n])), int'(iq_q(got_q[n])), ei, eq);
      else
        $display("FAIL %s[%0d]: missing, required I=%0d Q=%0d", name, n, ei, eq);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || underrun !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%h u=%b r=%b required v=0 d=0 u=0 r=1",
               out_valid, out_data, underrun, in_ready);
    end
  endtask

  task automatic test_single_burst();
    in_q.delete();
    in_q.push_back(mk(800, -800));
    in_q.push_back(mk(-800, 800));
    build_exp();
    run(0, "burst");
    check_iq("burst", 1, 100, -100);
    check_iq("burst", 7, 700, -700);
    check_iq("burst", 8, 800, -800);
    check_iq("burst", 9, 600, -600);
    check_iq("burst", 16, -800, 800);
    check_iq("burst", 23, -100, 100);
  endtask

  task automatic test_rounding();
    int ei[8] = '{0, 0, 0, 1, 1, 1, 2, 2};
    int eq[8] = '{0, -1, -1, -2, -2, -2, -3, -3};
    in_q.delete();
    in_q.push_back(mk(3, -3));
    build_exp();
    run(0, "rounding");
    for (int n = 0; n < 8; n++) check_iq("rounding", n, ei[n], eq[n]);
  endtask

  task automatic test_full_scale();
    in_q.delete();
    in_q.push_back(mk(2047, -2048));
    in_q.push_back(mk(-2048, 2047));
    build_exp();
    run(0, "full_scale");
    check_iq("full_scale", 8, 2047, -2048);
    check_iq("full_scale", 9, 1535, -1537);
    check_iq("full_scale", 15, -1537, 1535);
  endtask

  task automatic test_continuous();
    in_q.delete();
    for (int n = 0; n < 10; n++)
      in_q.push_back(mk($urandom_range(4095) - 2048, $urandom_range(4095) - 2048));
    build_exp();
    run(0, "continuous");
    for (int n = 1; n < acc_cyc.size(); n++) begin
      checks++;
      if (acc_cyc[n] - acc_cyc[n-1] != 8) begin
        failures++;
        $display("FAIL continuous in_ready_gap[%0d]: got %0d required 8", n, acc_cyc[n] - acc_cyc[n-1]);
      end
    end
    checks++;
    if (last_out - first_out + 1 != got_q.size()) begin
      failures++;
      $display("FAIL continuous bubble: got span %0d required %0d", last_out - first_out + 1, got_q.size());
    end
    checks++;
    if (acc_cyc.size() == 0 || und_cyc <= acc_cyc[acc_cyc.size()-1]) begin
      failures++;
      $display("FAIL continuous early_underrun: got cycle %0d required after last accept", und_cyc);
    end
  endtask

  task automatic test_backpressure();
    for (int b = 0; b < 4; b++) begin
      in_q.delete();
      for (int n = 0; n < 1 + int'($urandom_range(4)); n++)
        in_q.push_back(mk($urandom_range(4095) - 2048, $urandom_range(4095) - 2048));
      build_exp();
      run(45, "backpressure");
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    in_valid = 1'b1;
    in_data = mk(800, -800);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || int'(iq_i(out_data)) != 400 || int'(iq_q(out_data)) != -400) begin
      failures++;
      $display("FAIL mid_run_k4: got v=%b d=%h required v=1 I=400 Q=-400", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got v=%b d=%h u=%b required v=0 d=0 u=0", out_valid, out_data, underrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_q.delete();
    in_q.push_back(mk(-400, 1200));
    build_exp();
    run(0, "after_reset");
    check_iq("after_reset", 0, 0, 0);
    check_iq("after_reset", 4, -200, 600);
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single_burst();
    test_rounding();
    test_full_scale();
    test_continuous();
    test_backpressure();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_lin_interp.md
Name: tx_lin_interp

Overview:
- TX pulse-shaping stage placed directly downstream of the header inserter, consuming its {I,Q} symbol stream.
- Upsamples by L = 2^LOG2_L using linear interpolation between consecutive symbols, so the DAC path receives a smooth ramp instead of a held staircase.
- On input underrun it appends a ramp-down tail to zero, so every burst starts and ends at 0.

Parameters:
- DATA_W, 12: signed width of each of I and Q.
- LOG2_L, 3: log2 of the interpolation factor (L = 8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  AXIS input TVALID.
- in_data  in  2*DATA_W  input {I[23:12], Q[11:0]}, two's complement.
- in_ready  out  1  AXIS input TREADY.
- out_valid  out  1  AXIS output TVALID.
- out_data  out  2*DATA_W  output {I, Q}, two's complement.
- out_ready  in  1  AXIS output TREADY.
- underrun  out  1  one-cycle pulse when a tail segment starts.

Behaviour:
- Reset: one clock, rst_n asynchronous and active-low. The whole block clears immediately and asynchronously, including mid-segment:
  - state=IDLE; prev, cur, k, out_data all 0.
  - out_valid=0, underrun=0.
- Registers:
  - prev, cur: {I,Q} pairs.
  - k: LOG2_L-bit sample index.
  - state: IDLE, RUN or TAIL.
- Sample value, computed per component: s = prev + ((cur - prev) * k) >>> LOG2_L.
  - diff is DATA_W+1 bits; product is DATA_W+1+LOG2_L bits.
  - Shift is arithmetic, rounding toward -inf.
  - Result always lies between prev and cur, so it is truncated to DATA_W bits without saturation.
- out_data is registered. A transfer is out_valid && out_ready. The register is loaded with the sample for the next (state, k) on every transfer or segment start.
- in_ready = (state==IDLE) || (state==RUN && k==L-1 && out_ready). It is combinational from out_ready, which is allowed.
- IDLE:
  - out_valid=0.
  - On in_valid: cur<=in_data, k<=0, go RUN.
  - Next cycle out_valid=1 with out_data=prev. Latency from input acceptance to first output is 1 cycle.
- RUN:
  - out_valid=1. On transfer with k<L-1: k<=k+1.
  - On transfer with k==L-1 and in_valid: prev<=cur, cur<=in_data, k<=0, stay RUN. There is no bubble; sustained throughput is 1 input per L output cycles.
  - On transfer with k==L-1 and !in_valid: prev<=cur, cur<=0, k<=0, go TAIL, underrun pulses 1 cycle.
- TAIL:
  - out_valid=1, in_ready=0. Emits L samples ramping prev→0.
  - On transfer with k==L-1: prev<=0, go IDLE, out_valid=0 next cycle. An in_valid arriving during TAIL waits until IDLE.
- Backpressure: while out_valid && !out_ready, out_data, k, prev and cur all hold.
- Segment order: each symbol X's value appears as k=0 of the segment that follows it. The first segment of a burst ramps 0→X0.

Decomposition:
- Shared package tx_pkg holds:
  - IQ_W = 12;
  - the state enum {IDLE, RUN, TAIL};
  - a helper function that packs/unpacks {I,Q}.
- One natural sub-module, lin_interp_lane: the per-component combinational prev/cur/k → s arithmetic, instantiated twice (I, Q).
- The FSM, k counter and handshake stay in the top.

Test Plan:
- Single burst: after reset send I=800, Q=-800, then I=-800, Q=800, then stop.
  - Segment 1: I=0,100,...,700 and Q=0,-100,...,-700.
  - Segment 2: I=800,600,...,-600 and Q=-800,...,600.
  - Tail: I=-800,-700,...,-100; underrun pulses once; 24 outputs total, then out_valid=0.
- Rounding: prev=0.
  - cur I=3 gives I=0,0,0,1,1,1,2,2.
  - cur I=-3 gives -0,-1,-1,-2,-2,-2,-3,-3.
- Full-scale: symbols I=2047 then I=-2048.
  - Segment 2 is 2047 + floor(-4095k/8), i.e. 2047,1535,...,-1537.
  - No wrap; all values stay within [-2048, 2047].
- Continuous input with out_ready=1 and in_valid=1 throughout:
  - in_ready is high exactly once per 8 cycles, with no output bubble.
  - underrun never fires.
- Random out_ready backpressure:
  - out_data stays stable while stalled.
  - The output sequence matches the unstalled reference bit-exactly.
- rst_n asserted mid-RUN at k=4:
  - out_valid drops immediately.
  - The next burst's first segment starts from 0.
